cpld_uart_ctrl: RTL

CPLD_UART_CTRL -- requirements
Module: cpld_uart_ctrl

---
 rtl/cpu_uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 57 +++++
 rtl/cpld_uart_ctrl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cpu_uart_pkg.sv
// Shared definitions for the CPLD UART bridge: controller state codes and
// default bus timing.
package cpu_uart_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_RX_DEPTH  = 4;
  localparam int DEF_PULSE_CYC = 3;
  localparam int DEF_SETUP_CYC = 1;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE         = 3'd0;
  localparam state_t ST_RD_PULSE     = 3'd1;
  localparam state_t ST_RD_HOLD      = 3'd2;
  localparam state_t ST_WR_SETUP     = 3'd3;
  localparam state_t ST_WR_PULSE     = 3'd4;
  localparam state_t ST_WR_WAIT_TBRE = 3'd5;
  localparam state_t ST_WR_WAIT_TSRE = 3'd6;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO holding bytes read from the UART until the CPU
// consumes them.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; count/pointers alone
  // decide validity, and an un-reset array maps onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cpld_uart_ctrl.sv
// Bridges a CPU byte handshake to an external UART that shares the base-RAM
// data bus, generating rdn/wrn strobes and arbitrating for the bus.
module cpld_uart_ctrl
  import cpu_uart_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RX_DEPTH  = DEF_RX_DEPTH,
  parameter int PULSE_CYC = DEF_PULSE_CYC,
  parameter int SETUP_CYC = DEF_SETUP_CYC
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        tx_valid,
  input  logic [DATA_W-1:0]           tx_data,
  output logic                        tx_ready,
  output logic                        rx_valid,
  output logic [DATA_W-1:0]           rx_data,
  input  logic                        rx_ready,
  output logic [$clog2(RX_DEPTH):0]   rx_count,
  output logic                        busy,
  output logic                        bus_req,
  input  logic                        bus_gnt,
  input  logic [DATA_W-1:0]           bus_data_i,
  output logic [DATA_W-1:0]           bus_data_o,
  output logic                        bus_oe,
  output logic                        uart_rdn,
  output logic                        uart_wrn,
  input  logic                        uart_dataready,
  input  logic                        uart_tbre,
  input  logic                        uart_tsre
);

  localparam int CNT_MAX = (PULSE_CYC > SETUP_CYC) ? PULSE_CYC : SETUP_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [2:0]        sync1;
  logic [2:0]        sync2;
  logic              dr_s;
  logic              tbre_s;
  logic              tsre_s;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] rd_byte;
  logic [DATA_W-1:0] tx_hold;
  logic              tx_full;
  logic              fifo_full;
  logic              fifo_empty;
  logic              rd_pend;
  logic              wr_pend;
  logic              pulse_last;
  logic              setup_last;
  logic              wr_start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {uart_dataready, uart_tbre, uart_tsre};
      sync2 <= sync1;
    end
  end

  assign {dr_s, tbre_s, tsre_s} = sync2;

  assign rd_pend    = dr_s && !fifo_full;
  assign wr_pend    = tx_full;
  assign pulse_last = (cnt == CNT_W'(PULSE_CYC - 1));
  assign setup_last = (cnt == CNT_W'(SETUP_CYC - 1));
  assign wr_start   = (state == ST_IDLE) && (state_nxt == ST_WR_SETUP);
  assign tx_ready   = !tx_full;
  assign busy       = (state != ST_IDLE);
  assign rx_valid   = !fifo_empty;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bus_req   = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        bus_req = rd_pend || wr_pend;
        // Read wins when both are pending on the same grant.
        if (bus_gnt && rd_pend)      state_nxt = ST_RD_PULSE;
        else if (bus_gnt && wr_pend) state_nxt = ST_WR_SETUP;
      end
      ST_RD_PULSE: begin
        bus_req = 1'b1;
        if (pulse_last) begin
          state_nxt = ST_RD_HOLD;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RD_HOLD: state_nxt = ST_IDLE;
      ST_WR_SETUP: begin
        bus_req = 1'b1;
        if (setup_last) begin
          state_nxt = ST_WR_PULSE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_WR_PULSE: begin
        bus_req = 1'b1;
        if (pulse_last) begin
          state_nxt = ST_WR_WAIT_TBRE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_WR_WAIT_TBRE: if (tbre_s) state_nxt = ST_WR_WAIT_TSRE;
      ST_WR_WAIT_TSRE: if (tsre_s) state_nxt = ST_IDLE;
      default:         state_nxt = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they are glitch-free and
  // still fall back to idle levels the moment reset asserts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      uart_rdn   <= 1'b1;
      uart_wrn   <= 1'b1;
      bus_oe     <= 1'b0;
      bus_data_o <= '0;
      rd_byte    <= '0;
      tx_hold    <= '0;
      tx_full    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      uart_rdn <= (state_nxt != ST_RD_PULSE);
      uart_wrn <= (state_nxt != ST_WR_PULSE);
      bus_oe   <= (state_nxt == ST_WR_SETUP) || (state_nxt == ST_WR_PULSE);
      if ((state == ST_RD_PULSE) && pulse_last) rd_byte <= bus_data_i;
      if (wr_start) begin
        bus_data_o <= tx_hold;
        tx_full    <= 1'b0;
      end else if (tx_valid && !tx_full) begin
        tx_hold <= tx_data;
        tx_full <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (state == ST_RD_HOLD),
    .push_data (rd_byte),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .count     (rx_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule
